// File: rtl/microcode_sequencer_pkg.sv
// Shared definitions for the 8-bit CPU control unit: control-word bit map,
// opcode encodings, microstep numbers and the fixed control words.
package cpu_ctrl_pkg;

  localparam int CW_WIDTH = 17;

  // Control-word bit positions.
  localparam int HLT = 0;
  localparam int MI  = 1;
  localparam int RI  = 2;
  localparam int RO  = 3;
  localparam int IO  = 4;
  localparam int II  = 5;
  localparam int AI  = 6;
  localparam int AO  = 7;
  localparam int EO  = 8;
  localparam int SU  = 9;
  localparam int BI  = 10;
  localparam int BO  = 11;
  localparam int OI  = 12;
  localparam int CE  = 13;
  localparam int CO  = 14;
  localparam int J   = 15;
  localparam int FI  = 16;

  typedef logic [CW_WIDTH-1:0] cw_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;

  function automatic cw_t cw_bit(input int idx);
    return cw_t'(1) << idx;
  endfunction

  localparam cw_t CW_FETCH_ADDR = cw_bit(MI) | cw_bit(CO);
  localparam cw_t CW_FETCH_IR   = cw_bit(RO) | cw_bit(II) | cw_bit(CE);
  localparam cw_t CW_OPER_ADDR  = cw_bit(IO) | cw_bit(MI);
  localparam cw_t CW_LOAD_A     = cw_bit(RO) | cw_bit(AI);
  localparam cw_t CW_LOAD_B     = cw_bit(RO) | cw_bit(BI);
  localparam cw_t CW_SUM        = cw_bit(EO) | cw_bit(AI) | cw_bit(FI);
  localparam cw_t CW_DIFF       = cw_bit(EO) | cw_bit(AI) | cw_bit(SU) | cw_bit(FI);
  localparam cw_t CW_STORE_A    = cw_bit(AO) | cw_bit(RI);
  localparam cw_t CW_LOAD_IMM   = cw_bit(IO) | cw_bit(AI);
  localparam cw_t CW_JUMP       = cw_bit(IO) | cw_bit(J);
  localparam cw_t CW_OUTPUT     = cw_bit(AO) | cw_bit(OI);
  localparam cw_t CW_HALT       = cw_bit(HLT);

endpackage

// File: rtl/microcode_sequencer_rom.sv
// Combinational microcode table: maps opcode, microstep and latched flags to
// the control word, and flags the final microstep of the instruction.
module microcode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_STEPS  = 5,
  parameter int STEP_WIDTH = 3
) (
  input  logic [3:0]            opcode,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  flag_c,
  input  logic                  flag_z,
  input  logic                  early_end,
  output cw_t                   cw,
  output logic                  last
);

  localparam logic [STEP_WIDTH-1:0] S0     = STEP_WIDTH'(T0);
  localparam logic [STEP_WIDTH-1:0] S1     = STEP_WIDTH'(T1);
  localparam logic [STEP_WIDTH-1:0] S2     = STEP_WIDTH'(T2);
  localparam logic [STEP_WIDTH-1:0] S3     = STEP_WIDTH'(T3);
  localparam logic [STEP_WIDTH-1:0] S4     = STEP_WIDTH'(T4);
  localparam logic [STEP_WIDTH-1:0] S_LAST = STEP_WIDTH'(MAX_STEPS - 1);

  cw_t                   exec_cw;
  logic [STEP_WIDTH-1:0] op_last;
  logic                  legal;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    exec_cw = '0;
    op_last = S1;
    case (opcode)
      OP_LDA: begin
        op_last = S3;
        if (step == S2)      exec_cw = CW_OPER_ADDR;
        else if (step == S3) exec_cw = CW_LOAD_A;
      end
      OP_ADD, OP_SUB: begin
        op_last = S4;
        if (step == S2)      exec_cw = CW_OPER_ADDR;
        else if (step == S3) exec_cw = CW_LOAD_B;
        else if (step == S4) exec_cw = (opcode == OP_SUB) ? CW_DIFF : CW_SUM;
      end
      OP_STA: begin
        op_last = S3;
        if (step == S2)      exec_cw = CW_OPER_ADDR;
        else if (step == S3) exec_cw = CW_STORE_A;
      end
      OP_LDI: begin
        op_last = S2;
        if (step == S2) exec_cw = CW_LOAD_IMM;
      end
      OP_JMP: begin
        op_last = S2;
        if (step == S2) exec_cw = CW_JUMP;
      end
      // Conditional jumps still spend T2 when not taken, so timing is fixed.
      OP_JC: begin
        op_last = S2;
        if (step == S2 && flag_c) exec_cw = CW_JUMP;
      end
      OP_JZ: begin
        op_last = S2;
        if (step == S2 && flag_z) exec_cw = CW_JUMP;
      end
      OP_OUT: begin
        op_last = S2;
        if (step == S2) exec_cw = CW_OUTPUT;
      end
      OP_HLT: begin
        op_last = S2;
        if (step == S2) exec_cw = CW_HALT;
      end
      default: ;
    endcase
  end

  assign legal = (step <= S_LAST);

  always_comb begin
    cw = '0;
    if (legal) begin
      if (step == S0)      cw = CW_FETCH_ADDR;
      else if (step == S1) cw = CW_FETCH_IR;
      else                 cw = exec_cw;
    end
  end

  // An out-of-range step counts as last so the counter recovers to T0.
  assign last = !legal || (step == (early_end ? op_last : S_LAST));

endmodule

// File: rtl/microcode_sequencer.sv
// CPU control unit top: microstep counter, carry/zero flag register and halt
// state around the combinational microcode table.
module microcode_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_STEPS  = 5,
  parameter int STEP_WIDTH = 3,
  parameter int EARLY_END  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [3:0]            ir_opcode,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  output logic [CW_WIDTH-1:0]   ctrl,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic                  halted,
  output logic                  instr_done
);

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } run_state_e;

  localparam logic EARLY_END_BIT = (EARLY_END != 0);

  run_state_e state;
  cw_t        rom_cw;
  logic       rom_last;
  logic       advance;

  microcode_rom #(
    .MAX_STEPS  (MAX_STEPS),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_rom (
    .opcode    (ir_opcode),
    .step      (step),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .early_end (EARLY_END_BIT),
    .cw        (rom_cw),
    .last      (rom_last)
  );

  assign halted     = (state == ST_HALT);
  assign ctrl       = halted ? CW_HALT : rom_cw;
  assign advance    = clk_en && !halted;
  assign instr_done = advance && rom_last;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state  <= ST_RUN;
      step   <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (advance) begin
      // Halting freezes the step at the HLT microstep; only reset leaves.
      if (rom_cw[HLT])   state <= ST_HALT;
      else if (rom_last) step  <= '0;
      else               step  <= step + STEP_WIDTH'(1);
      if (rom_cw[FI]) begin
        flag_c <= alu_carry;
        flag_z <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: an early-end and a full-length instance run
// side by side against a table-driven instruction model plus literal checks.
module tb_microcode_sequencer;

  localparam int MAX_STEPS = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic [3:0]  ir_opcode = 4'h5;
  logic        alu_carry = 1'b0;
  logic        alu_zero = 1'b0;

  logic [16:0] ctrl_o [2];
  logic [2:0]  step_o [2];
  logic        fc_o [2];
  logic        fz_o [2];
  logic        halt_o [2];
  logic        done_o [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  microcode_sequencer #(.MAX_STEPS(5), .STEP_WIDTH(3), .EARLY_END(1)) dut_early (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .ir_opcode(ir_opcode),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .ctrl(ctrl_o[0]), .step(step_o[0]),
    .flag_c(fc_o[0]), .flag_z(fz_o[0]), .halted(halt_o[0]), .instr_done(done_o[0])
  );

  microcode_sequencer #(.MAX_STEPS(5), .STEP_WIDTH(3), .EARLY_END(0)) dut_full (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .ir_opcode(ir_opcode),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .ctrl(ctrl_o[1]), .step(step_o[1]),
    .flag_c(fc_o[1]), .flag_z(fz_o[1]), .halted(halt_o[1]), .instr_done(done_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  int m_step [2] = '{0, 0};
  bit m_fc   [2] = '{0, 0};
  bit m_fz   [2] = '{0, 0};
  bit m_halt [2] = '{0, 0};

  // Execute-phase words T2..T4 for an opcode (k = 0..2).
  function automatic logic [16:0] exec_word(input logic [3:0] op, input int k,
                                            input bit fc, input bit fz);
    logic [16:0] prog [3];
    prog = '{17'h0, 17'h0, 17'h0};
    case (op)
      4'h1: prog = '{17'h00012, 17'h00048, 17'h00000};
      4'h2: prog = '{17'h00012, 17'h00408, 17'h10140};
      4'h3: prog = '{17'h00012, 17'h00408, 17'h10340};
      4'h4: prog = '{17'h00012, 17'h00084, 17'h00000};
      4'h5: prog = '{17'h00050, 17'h00000, 17'h00000};
      4'h6: prog = '{17'h08010, 17'h00000, 17'h00000};
      4'h7: prog = '{fc ? 17'h08010 : 17'h0, 17'h00000, 17'h00000};
      4'h8: prog = '{fz ? 17'h08010 : 17'h0, 17'h00000, 17'h00000};
      4'hE: prog = '{17'h01080, 17'h00000, 17'h00000};
      4'hF: prog = '{17'h00001, 17'h00000, 17'h00000};
      default: ;
    endcase
    return (k >= 0 && k < 3) ? prog[k] : 17'h0;
  endfunction

  // Number of microsteps including the two fetch steps.
  function automatic int prog_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int last_step(input int i, input logic [3:0] op);
    return (i == 0) ? prog_len(op) - 1 : MAX_STEPS - 1;
  endfunction

  function automatic logic [16:0] model_ctrl(input int i, input logic [3:0] op);
    if (m_halt[i])        return 17'h00001;
    if (m_step[i] == 0)   return 17'h04002;
    if (m_step[i] == 1)   return 17'h02028;
    return exec_word(op, m_step[i] - 2, m_fc[i], m_fz[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_update
    logic [16:0] w;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_step[i] = 0;
        m_fc[i]   = 1'b0;
        m_fz[i]   = 1'b0;
        m_halt[i] = 1'b0;
      end else if (clk_en && !m_halt[i]) begin
        w = model_ctrl(i, ir_opcode);
        if (w[16]) begin
          m_fc[i] = alu_carry;
          m_fz[i] = alu_zero;
        end
        if (w[0])                                   m_halt[i] = 1'b1;
        else if (m_step[i] == last_step(i, ir_opcode)) m_step[i] = 0;
        else                                        m_step[i] = m_step[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d.ctrl", i), 32'(ctrl_o[i]), 32'(model_ctrl(i, ir_opcode)));
        check($sformatf("dut%0d.step", i), 32'(step_o[i]), 32'(m_step[i]));
        check($sformatf("dut%0d.flag_c", i), 32'(fc_o[i]), 32'(m_fc[i]));
        check($sformatf("dut%0d.flag_z", i), 32'(fz_o[i]), 32'(m_fz[i]));
        check($sformatf("dut%0d.halted", i), 32'(halt_o[i]), 32'(m_halt[i]));
        check($sformatf("dut%0d.instr_done", i), 32'(done_o[i]),
              32'(clk_en && !m_halt[i] && m_step[i] == last_step(i, ir_opcode)));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int en_seq [4]    = '{1, 0, 0, 1};
  int step_seq [5]  = '{0, 1, 1, 1, 2};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench time limit");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // LDI on both instances; the full-length one also covers T3/T4 idle words.
    @(negedge clk);
    check("t1.reset_ctrl", 32'(ctrl_o[0]), 32'h04002);
    check("t1.reset_step", 32'(step_o[0]), 0);
    tick(); @(negedge clk);
    check("t1.fetch_ir", 32'(ctrl_o[0]), 32'h02028);
    tick(); @(negedge clk);
    check("t1.ldi_word", 32'(ctrl_o[0]), 32'h00050);
    check("t1.ldi_done", 32'(done_o[0]), 1);
    tick(); @(negedge clk);
    check("t1.wrap_ctrl", 32'(ctrl_o[0]), 32'h04002);
    check("t6.full_t3_ctrl", 32'(ctrl_o[1]), 0);
    check("t6.full_t3_done", 32'(done_o[1]), 0);
    tick(); @(negedge clk);
    check("t6.full_t4_step", 32'(step_o[1]), 4);
    check("t6.full_t4_ctrl", 32'(ctrl_o[1]), 0);
    check("t6.full_t4_done", 32'(done_o[1]), 1);
    tick(); @(negedge clk);
    check("t6.full_wrap", 32'(step_o[1]), 0);

    // ADD sets carry, then JC is taken and JZ is not.
    apply_reset();
    ir_opcode = 4'h2; alu_carry = 1'b1; alu_zero = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("t2.add_t4", 32'(ctrl_o[0]), 32'h10140);
    tick(); @(negedge clk);
    check("t2.flag_c", 32'(fc_o[0]), 1);
    check("t2.flag_z", 32'(fz_o[0]), 0);
    ir_opcode = 4'h7;
    tick(); tick(); @(negedge clk);
    check("t2.jc_taken", 32'(ctrl_o[0]), 32'h08010);
    tick();
    ir_opcode = 4'h8;
    tick(); tick(); @(negedge clk);
    check("t2.jz_not_taken", 32'(ctrl_o[0]), 0);
    check("t2.jz_done", 32'(done_o[0]), 1);
    tick(); @(negedge clk);
    check("t2.jz_end_t2", 32'(step_o[0]), 0);

    // LDA with clk_en stalls.
    apply_reset();
    ir_opcode = 4'h1; alu_carry = 1'b1; alu_zero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      clk_en = en_seq[k][0];
      @(negedge clk);
      check($sformatf("t3.step%0d", k), 32'(step_o[0]), 32'(step_seq[k]));
      if (k > 0) check($sformatf("t3.ctrl%0d", k), 32'(ctrl_o[0]), 32'h02028);
      tick();
    end
    @(negedge clk);
    check("t3.step4", 32'(step_o[0]), 2);
    check("t3.flags", 32'({fc_o[0], fz_o[0]}), 0);

    // HLT: frozen under random inputs until reset.
    apply_reset();
    ir_opcode = 4'hF; clk_en = 1'b1;
    tick(); tick(); @(negedge clk);
    check("t4.hlt_word", 32'(ctrl_o[0]), 32'h00001);
    check("t4.not_yet_halted", 32'(halt_o[0]), 0);
    tick();
    for (int k = 0; k < 20; k++) begin
      clk_en    = 1'($urandom_range(0, 1));
      alu_carry = 1'($urandom_range(0, 1));
      alu_zero  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("t4.halted", 32'(halt_o[0]), 1);
      check("t4.step_hold", 32'(step_o[0]), 2);
      check("t4.ctrl_hold", 32'(ctrl_o[0]), 32'h00001);
      tick();
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4.rst_halted", 32'(halt_o[0]), 0);
    check("t4.rst_step", 32'(step_o[0]), 0);
    check("t4.rst_ctrl", 32'(ctrl_o[0]), 32'h04002);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // SUB sets both flags, then an async reset lands mid-instruction.
    ir_opcode = 4'h3; clk_en = 1'b1; alu_carry = 1'b1; alu_zero = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("t5.flags_set", 32'({fc_o[0], fz_o[0]}), 32'h3);
    repeat (3) tick();
    @(negedge clk);
    check("t5.at_t3", 32'(step_o[0]), 3);
    #2 rst_n = 1'b0;
    #1;
    check("t5.async_step", 32'(step_o[0]), 0);
    check("t5.async_flags", 32'({fc_o[0], fz_o[0]}), 0);
    check("t5.async_ctrl", 32'(ctrl_o[0]), 32'h04002);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Full control unit for the 8-bit CPU. It steps through the microinstruction phases of each instruction and decodes the opcode, step and latched ALU flags into the bus control word.
- Owns the step counter, the carry/zero flag register and the halt state.
- Sits between the instruction register and the datapath.
- The datapath acts on control signals only in cycles where clk_en=1.

Parameters:
- MAX_STEPS, 5: steps per instruction when no early end; counter wraps from MAX_STEPS-1 to 0.
- STEP_WIDTH, 3: width of the step counter.
- EARLY_END, 1: 1 = return to step 0 after the last active step of each opcode; 0 = every instruction takes MAX_STEPS.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- clk_en, input, 1: advance qualifier from the clock module (auto, manual or single-step).
- ir_opcode, input, 4: IR upper nibble; read combinationally, valid from step 2.
- alu_carry, input, 1: ALU carry out.
- alu_zero, input, 1: ALU result == 0.
- ctrl, output, 17: control word, bit map below.
- step, output, STEP_WIDTH: current microstep.
- flag_c, output, 1: latched carry flag.
- flag_z, output, 1: latched zero flag.
- halted, output, 1: CPU stopped.
- instr_done, output, 1: current cycle completes an instruction.

Behaviour:
- Control word bit map: 0 HLT, 1 MI, 2 RI, 3 RO, 4 IO, 5 II, 6 AI, 7 AO, 8 EO, 9 SU, 10 BI, 11 BO, 12 OI, 13 CE, 14 CO, 15 J, 16 FI.
- Reset (async, rst_n=0): step=0, flag_c=0, flag_z=0, halted=0. ctrl therefore shows 0x04002 while in reset and after release.
- ctrl is combinational from the registered step, the flags, halted and ir_opcode. No added latency.
- Fetch words, all opcodes:
  - T0 = MI|CO (0x04002)
  - T1 = RO|II|CE (0x02028)
- Execute words by opcode:
  - LDA 0001: T2 IO|MI (0x00012); T3 RO|AI (0x00048).
  - ADD 0010: T2 IO|MI; T3 RO|BI (0x00408); T4 EO|AI|FI (0x10140).
  - SUB 0011: as ADD, but T4 = EO|AI|SU|FI (0x10340).
  - STA 0100: T2 IO|MI; T3 AO|RI (0x00084).
  - LDI 0101: T2 IO|AI (0x00050).
  - JMP 0110: T2 IO|J (0x08010).
  - JC 0111: T2 = IO|J if flag_c, else 0.
  - JZ 1000: T2 = IO|J if flag_z, else 0.
  - OUT 1110: T2 AO|OI (0x01080).
  - HLT 1111: T2 HLT (0x00001).
  - NOP 0000 and undefined opcodes: all execute steps 0.
- Last step with EARLY_END=1:
  - NOP/undefined: T1.
  - LDI, JMP, JC, JZ, OUT, HLT: T2. JC/JZ end at T2 whether or not the jump is taken.
  - LDA, STA: T3.
  - ADD, SUB: T4.
- Last step with EARLY_END=0: MAX_STEPS-1 for every opcode.
- Advance on a clk_en=1 edge with halted=0:
  - step <= 0 if on the last step, else step+1.
  - instr_done = clk_en & last & ~halted (combinational).
- clk_en=0: step, flags and halted hold; ctrl is stable.
- Flags: on a clk_en=1 edge with ctrl[FI]=1, flag_c<=alu_carry and flag_z<=alu_zero. Otherwise the flags hold.
- Halt:
  - On a clk_en=1 edge with ctrl[HLT]=1, halted<=1 and step holds at 2.
  - While halted: ctrl=0x00001 and instr_done=0. clk_en and the ALU inputs are ignored.
  - Only rst_n exits the halt state.
- Reset mid-instruction: immediate abort to step 0; flags are cleared; no partial word persists.
- Step wrap: the counter never exceeds MAX_STEPS-1. An illegal step value decodes ctrl=0 and next step=0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - control-bit index localparams and CW_WIDTH=17;
  - opcode constants;
  - step constants T0..T4.
- Sub-module microcode_rom: purely combinational. Inputs opcode, step, flag_c, flag_z, early_end. Outputs the control word and a last-step flag.
- The top level keeps the step counter, the flag register and the halt register.

Test Plan:
1. Reset released, clk_en=1, ir_opcode=0101 → ctrl sequence 0x04002, 0x02028, 0x00050, 0x04002. instr_done high in the third cycle; step returns to 0.
2. ADD with alu_carry=1, alu_zero=0 at T4 → ctrl 0x10140 at step 4; flag_c=1, flag_z=0 from the next cycle. Then JC → T2 ctrl 0x08010. Then JZ → T2 ctrl 0x00000, and the instruction still ends at T2.
3. clk_en toggled 1,0,0,1 during LDA → step 0,1,1,1,2; ctrl constant while clk_en=0; the flags do not change.
4. HLT opcode → at step 2, ctrl=0x00001. After a clk_en edge, halted=1, and step=2 and ctrl=0x00001 hold for 20 cycles of random clk_en and ALU inputs. Asserting rst_n=0 → halted=0, step=0, ctrl=0x04002.
5. Reset asserted asynchronously mid-SUB at step 3 → step=0, flags=0 without waiting for a clock edge.
6. EARLY_END=0 with opcode 0101 → steps 0..4 visited; ctrl=0 at steps 3 and 4; instr_done only at step 4.
